// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide scheduler: op codes, latencies, op classification.
// Optional MADD/MSUB support is enabled with the MDU_MADD_EN macro.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles; MADD/MSUB only when built in.
  function automatic logic is_multicycle(input logic [2:0] op);
    logic mc;
    mc = (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
`ifdef MDU_MADD_EN
    mc = mc || (op == MD_MADD) || (op == MD_MSUB);
`endif
    return mc;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {hi,lo} result for the issued op plus a divide-by-zero flag.
// MADD/MSUB accumulate onto the current hi/lo only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div0
);

  logic        mul_sgn, div_sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // One shared multiplier: sign-extending to 64 bits makes the low 64 product bits correct for both signs.
  assign mul_sgn = (op != MD_MULTU);
  assign a_ext   = {{32{mul_sgn & rs[31]}}, rs};
  assign b_ext   = {{32{mul_sgn & rt[31]}}, rt};
  assign prod    = a_ext * b_ext;

  assign div_sgn = (op == MD_DIV);
  assign a_neg   = div_sgn & rs[31];
  assign b_neg   = div_sgn & rt[31];
  assign a_mag   = a_neg ? -rs : rs;
  assign b_mag   = b_neg ? -rt : rt;
  assign div0    = is_div(op) && (rt == 32'd0);
  assign b_safe  = (rt == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    res = {hi, lo};
    case (op)
      MD_MULT, MD_MULTU: res = prod;
      MD_DIV, MD_DIVU:   res = {rem, quo};
`ifdef MDU_MADD_EN
      MD_MADD:           res = {hi, lo} + prod;
      MD_MSUB:           res = {hi, lo} - prod;
`endif
      default:           res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler: owns HI/LO, models multi-cycle latency with a countdown and raises the D-stage stall.
// MDU_MADD_EN adds MADD/MSUB (accumulate into {hi,lo}) with multiply latency.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] arith_res;
  logic        arith_div0;

  mdu_arith u_arith (
    .op   (md_op),
    .rs   (rs_val),
    .rt   (rt_val),
    .hi   (hi_q),
    .lo   (lo_q),
    .res  (arith_res),
    .div0 (arith_div0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_multicycle(md_op)) begin
            state_d = S_RUN;
            cnt_d   = is_div(md_op) ? DIV_CNT : MULT_CNT;
            pend_d  = arith_res;
            div0_d  = arith_div0;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      S_RUN: begin
        // A start seen here is a pipeline protocol error and is dropped.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (!div0_q) {hi_d, lo_d} = pend_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = md_use_d & (busy | (start & is_multicycle(md_op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
